traffic_phase_ctrl: RTL and testbench
=====================================

Name: traffic_phase_ctrl

Overview:
- Generalised intersection controller for N main-road phases served round-robin, plus one demand-driven farm-road phase.
- Adds the following:
  - an all-red clearance interval after every yellow;
  - a latched farm request;
  - min/max farm green with early gap-out;
  - a preemptive flash (maintenance) mode.
- The integrated interval timer replaces the external down-counter.
- Sits between the sensor/maintenance inputs and the lamp drivers.

Parameters:
- NUM_PHASES, 2: number of main-road phases (>=2).
- CNT_W, 5: interval timer width; must hold max(T_*)-1.
- T_GREEN, 8: main green length in cycles.
- T_YELLOW, 3: yellow length, main and farm.
- T_ALLRED, 2: all-red clearance length.
- T_FARM_MIN, 4: minimum farm green.
- T_FARM_MAX, 10: maximum farm green (>= T_FARM_MIN).
- T_FLASH, 4: flash half-period in cycles.
- All T_* >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset (one clock; reset is asynchronous and active-high)
- farm_req  in  1  farm-road vehicle sensor, level or pulse
- flash  in  1  maintenance flash request, level
- green  out  NUM_PHASES  main green lamps, one-hot or zero
- yellow  out  NUM_PHASES  main yellow lamps
- red  out  NUM_PHASES  main red lamps
- fg, fy, fr  out  1 each  farm green/yellow/red
- phase  out  PW  current/last main phase index; PW = max(1, clog2(NUM_PHASES))
- elapsed  out  CNT_W  cycles spent in the current interval
- farm_pending  out  1  latched farm request

Behaviour:
- States:
  - GREEN: main green for `phase`.
  - YELLOW: main yellow for `phase`.
  - ALLRED: clearance; every red lamp on, including fr.
  - FGREEN: farm green.
  - FYELLOW: farm yellow.
  - FLASH: maintenance flash.
- Timer and outputs:
  - `elapsed` clears to 0 on every state entry and increments each cycle in the state. An interval of length T ends on the cycle where elapsed==T-1, so each state lasts exactly T cycles.
  - Outputs are Moore-decoded from registered state and `phase` only; there is no input-to-output combinational path.
  - Lamps of any phase not currently served show red, except in FLASH.
- Reset (async, while rst=1):
  - State GREEN, phase=0, elapsed=0, farm_pending=0, flash blink bit=1.
  - Outputs: green[0]=1, red[others]=1, fr=1, all other lamps 0.
- Transitions:
  - GREEN -> YELLOW after T_GREEN.
  - YELLOW -> ALLRED after T_YELLOW.
  - ALLRED ends after T_ALLRED:
    - If the ALLRED followed a main yellow and farm_pending=1: -> FGREEN.
    - Otherwise: -> GREEN with phase = phase+1, wrapping NUM_PHASES-1 -> 0.
    - ALLRED after FYELLOW always goes to GREEN of the next phase; the farm road interleaves and never gets back-to-back service.
  - FGREEN:
    - -> FYELLOW when elapsed==T_FARM_MAX-1, or when elapsed>=T_FARM_MIN-1 and farm_req==0 (gap-out).
    - Minimum length T_FARM_MIN; maximum T_FARM_MAX.
  - FYELLOW -> ALLRED after T_YELLOW.
- farm_pending:
  - Set on any cycle with farm_req=1 while the state is not FGREEN.
  - Cleared on the FGREEN entry cycle.
  - If set and clear coincide, clear wins.
- Flash:
  - flash=1 in any state -> FLASH on the next cycle, aborting the current interval.
  - In FLASH: red=0, fr=0, green=0, fg=0. All yellow lamps and fy equal the blink bit.
  - The blink bit is 1 on entry and toggles every T_FLASH cycles; elapsed wraps at T_FLASH-1.
  - flash=0 while in FLASH -> ALLRED next cycle, then GREEN with phase=0.
  - farm_pending is retained and keeps latching during FLASH; it is serviced after the first completed main phase.
- Priority: rst > flash > interval end > hold.
- Reset asserted mid-interval returns to the reset state immediately; partial intervals are discarded.

Decomposition:
- Shared package traffic_pkg:
  - State encoding: S_GREEN, S_YELLOW, S_ALLRED, S_FGREEN, S_FYELLOW, S_FLASH (3-bit).
  - Default timing constants.
  - A flag encoding the origin of an ALLRED (main/farm/flash).
- One sub-module, interval_timer: CNT_W up-counter with synchronous clear-on-entry, async rst, and a `done` compare against a length input.
- The FSM, request latch, blink bit and lamp decode stay in traffic_phase_ctrl.

Test Plan:
- Defaults, rst released at cycle 0, farm_req=0, flash=0 -> sequence:
  - green[0] cycles 0-7, yellow[0] 8-10, all red 11-12;
  - green[1] 13-20, yellow[1] 21-23, all red 24-25;
  - green[0] again at 26 with phase=0 (wrap).
- 1-cycle farm_req pulse at cycle 3 -> farm_pending=1 from cycle 4.
  - After yellow[0] and all-red: fg cycles 13-16 (min 4 via gap-out, pending cleared at 13), fy 17-19, all red 20-21.
  - green[1] at 22.
- farm_req held high throughout -> fg lasts exactly 10 cycles (max).
  - The next farm service comes only after green[1] completes.
- farm_req high until FGREEN elapsed=6, low from elapsed=6 -> fg lasts 7 cycles.
- flash raised at elapsed=2 of green[1]:
  - Next cycle: all reds 0, all yellows and fy 1 for 4 cycles, 0 for 4 cycles, repeating.
  - flash lowered -> 2 all-red cycles, then green[0], phase=0.
- rst pulsed during FGREEN elapsed=5 -> the same cycle shows green[0]=1, fg=0, elapsed=0, farm_pending=0.
  - After release, normal cycle timing restarts from the reset state.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and default timing for the intersection phase controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_GREEN   = 3'd0,
        S_YELLOW  = 3'd1,
        S_ALLRED  = 3'd2,
        S_FGREEN  = 3'd3,
        S_FYELLOW = 3'd4,
        S_FLASH   = 3'd5
    } state_t;

    // Which interval led into the current all-red clearance.
    typedef enum logic [1:0] {
        ORG_MAIN  = 2'd0,
        ORG_FARM  = 2'd1,
        ORG_FLASH = 2'd2
    } ar_origin_t;

    localparam int DEF_NUM_PHASES = 2;
    localparam int DEF_CNT_W      = 5;
    localparam int DEF_T_GREEN    = 8;
    localparam int DEF_T_YELLOW   = 3;
    localparam int DEF_T_ALLRED   = 2;
    localparam int DEF_T_FARM_MIN = 4;
    localparam int DEF_T_FARM_MAX = 10;
    localparam int DEF_T_FLASH    = 4;

    function automatic int phase_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_interval_timer.sv
// Interval up-counter: restarts on state entry and flags the last cycle of a length.
module interval_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W:0]   len,
    output logic [CNT_W-1:0] elapsed,
    output logic             done
);

    logic [CNT_W-1:0] count_r;

    // Elapsed-cycle counter; a clear makes the next cycle read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    // One bit wider than the counter so a length of 2**CNT_W still compares correctly.
    assign elapsed = count_r;
    assign done    = ({1'b0, count_r} == (len - (CNT_W + 1)'(1)));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin main-road phase controller with demand-driven farm phase,
// all-red clearance and maintenance flash; lamps are Moore-decoded.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int T_GREEN    = DEF_T_GREEN,
    parameter int T_YELLOW   = DEF_T_YELLOW,
    parameter int T_ALLRED   = DEF_T_ALLRED,
    parameter int T_FARM_MIN = DEF_T_FARM_MIN,
    parameter int T_FARM_MAX = DEF_T_FARM_MAX,
    parameter int T_FLASH    = DEF_T_FLASH,
    localparam int PW        = phase_width(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  farm_req,
    input  logic                  flash,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] red,
    output logic                  fg,
    output logic                  fy,
    output logic                  fr,
    output logic [PW-1:0]         phase,
    output logic [CNT_W-1:0]      elapsed,
    output logic                  farm_pending
);

    localparam logic [CNT_W:0] L_GREEN    = (CNT_W + 1)'(T_GREEN);
    localparam logic [CNT_W:0] L_YELLOW   = (CNT_W + 1)'(T_YELLOW);
    localparam logic [CNT_W:0] L_ALLRED   = (CNT_W + 1)'(T_ALLRED);
    localparam logic [CNT_W:0] L_FARM_MAX = (CNT_W + 1)'(T_FARM_MAX);
    localparam logic [CNT_W:0] L_FLASH    = (CNT_W + 1)'(T_FLASH);
    localparam logic [CNT_W:0] L_FMIN_M1  = (CNT_W + 1)'(T_FARM_MIN - 1);
    localparam logic [PW-1:0]  LAST_PHASE = PW'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] ONE_HOT0 = NUM_PHASES'(1);

    state_t           state_r;
    state_t           state_s;
    ar_origin_t       origin_r;
    ar_origin_t       origin_s;
    logic [PW-1:0]    phase_r;
    logic [PW-1:0]    phase_s;
    logic [PW-1:0]    phase_inc_s;
    logic             pending_r;
    logic             pending_s;
    logic             blink_r;
    logic             blink_s;
    logic [CNT_W:0]   len_s;
    logic [CNT_W-1:0] elapsed_s;
    logic             done_s;
    logic             clear_s;
    logic             min_met_s;

    interval_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_s),
        .len     (len_s),
        .elapsed (elapsed_s),
        .done    (done_s)
    );

    // Interval length of the state currently being timed.
    always_comb begin
        case (state_r)
            S_GREEN:   len_s = L_GREEN;
            S_YELLOW:  len_s = L_YELLOW;
            S_ALLRED:  len_s = L_ALLRED;
            S_FGREEN:  len_s = L_FARM_MAX;
            S_FYELLOW: len_s = L_YELLOW;
            S_FLASH:   len_s = L_FLASH;
            default:   len_s = L_ALLRED;
        endcase
    end

    assign min_met_s   = ({1'b0, elapsed_s} >= L_FMIN_M1);
    assign phase_inc_s = (phase_r == LAST_PHASE) ? '0 : (phase_r + PW'(1));

    // State, phase, clearance origin, request latch and blink bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_GREEN;
            origin_r  <= ORG_MAIN;
            phase_r   <= '0;
            pending_r <= 1'b0;
            blink_r   <= 1'b1;
        end else begin
            state_r   <= state_s;
            origin_r  <= origin_s;
            phase_r   <= phase_s;
            pending_r <= pending_s;
            blink_r   <= blink_s;
        end
    end

    // Next-state selection: flash preempts, otherwise advance on interval end.
    always_comb begin
        state_s  = state_r;
        origin_s = origin_r;
        phase_s  = phase_r;
        if (flash) begin
            state_s = S_FLASH;
        end else begin
            case (state_r)
                S_GREEN: begin
                    state_s = done_s ? S_YELLOW : S_GREEN;
                end
                S_YELLOW: begin
                    if (done_s) begin
                        state_s  = S_ALLRED;
                        origin_s = ORG_MAIN;
                    end else begin
                        state_s  = S_YELLOW;
                    end
                end
                S_ALLRED: begin
                    if (!done_s) begin
                        state_s = S_ALLRED;
                    end else if ((origin_r == ORG_MAIN) && pending_r) begin
                        state_s = S_FGREEN;
                    end else begin
                        state_s = S_GREEN;
                        phase_s = (origin_r == ORG_FLASH) ? '0 : phase_inc_s;
                    end
                end
                S_FGREEN: begin
                    state_s = (done_s || (min_met_s && !farm_req)) ? S_FYELLOW : S_FGREEN;
                end
                S_FYELLOW: begin
                    if (done_s) begin
                        state_s  = S_ALLRED;
                        origin_s = ORG_FARM;
                    end else begin
                        state_s  = S_FYELLOW;
                    end
                end
                S_FLASH: begin
                    state_s  = S_ALLRED;
                    origin_s = ORG_FLASH;
                end
                default: begin
                    state_s  = S_ALLRED;
                    origin_s = ORG_FLASH;
                    phase_s  = '0;
                end
            endcase
        end
    end

    // Every transition restarts the timer; flash also wraps it each half-period.
    assign clear_s = (state_s != state_r) || ((state_r == S_FLASH) && done_s);

    // Request latch (clear on farm-green entry beats a coincident set) and blink bit.
    always_comb begin
        if ((state_s == S_FGREEN) && (state_r != S_FGREEN)) begin
            pending_s = 1'b0;
        end else if (farm_req && (state_r != S_FGREEN)) begin
            pending_s = 1'b1;
        end else begin
            pending_s = pending_r;
        end
        if (state_r != S_FLASH) begin
            blink_s = 1'b1;
        end else if ((state_s == S_FLASH) && done_s) begin
            blink_s = ~blink_r;
        end else begin
            blink_s = blink_r;
        end
    end

    // Lamp decode from registered state and phase only.
    always_comb begin
        green        = '0;
        yellow       = '0;
        red          = '1;
        fg           = 1'b0;
        fy           = 1'b0;
        fr           = 1'b1;
        phase        = phase_r;
        elapsed      = elapsed_s;
        farm_pending = pending_r;
        case (state_r)
            S_GREEN: begin
                green = ONE_HOT0 << phase_r;
                red   = ~(ONE_HOT0 << phase_r);
            end
            S_YELLOW: begin
                yellow = ONE_HOT0 << phase_r;
                red    = ~(ONE_HOT0 << phase_r);
            end
            S_ALLRED: begin
                red = '1;
            end
            S_FGREEN: begin
                fg = 1'b1;
                fr = 1'b0;
            end
            S_FYELLOW: begin
                fy = 1'b1;
                fr = 1'b0;
            end
            S_FLASH: begin
                red    = '0;
                fr     = 1'b0;
                yellow = {NUM_PHASES{blink_r}};
                fy     = blink_r;
            end
            default: begin
                red = '1;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench: stimulus pushes hand-derived lamp/timer expectations per cycle,
// a monitor pops and compares them mid-cycle.
module tb_traffic_phase_ctrl;

    localparam int ST_G  = 0;
    localparam int ST_Y  = 1;
    localparam int ST_A  = 2;
    localparam int ST_FG = 3;
    localparam int ST_FY = 4;
    localparam int ST_FL = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       farm_req;
    logic       flash;
    logic [1:0] green;
    logic [1:0] yellow;
    logic [1:0] red;
    logic       fg;
    logic       fy;
    logic       fr;
    logic [0:0] phase;
    logic [4:0] elapsed;
    logic       farm_pending;

    typedef struct packed {
        logic [1:0] green;
        logic [1:0] yellow;
        logic [1:0] red;
        logic       fg;
        logic       fy;
        logic       fr;
        logic       phase;
        logic [4:0] elapsed;
        logic       pend;
    } obs_t;

    typedef struct {
        obs_t e;
        int   scen;
        int   cyc;
    } item_t;

    item_t exp_q[$];
    int    n_vec = 0;
    int    n_miss = 0;
    int    scen = 0;
    int    cyc_i = 0;

    traffic_phase_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .farm_req     (farm_req),
        .flash        (flash),
        .green        (green),
        .yellow       (yellow),
        .red          (red),
        .fg           (fg),
        .fy           (fy),
        .fr           (fr),
        .phase        (phase),
        .elapsed      (elapsed),
        .farm_pending (farm_pending)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input int st, input int ph, input int el,
                                input logic pend, input logic blink);
        obs_t e;
        e         = '0;
        e.phase   = 1'(ph);
        e.elapsed = 5'(el);
        e.pend    = pend;
        case (st)
            ST_G:    begin e.green[ph] = 1'b1;  e.red = ~e.green;  e.fr = 1'b1; end
            ST_Y:    begin e.yellow[ph] = 1'b1; e.red = ~e.yellow; e.fr = 1'b1; end
            ST_A:    begin e.red = 2'b11; e.fr = 1'b1; end
            ST_FG:   begin e.red = 2'b11; e.fg = 1'b1; end
            ST_FY:   begin e.red = 2'b11; e.fy = 1'b1; end
            ST_FL:   begin e.yellow = {2{blink}}; e.fy = blink; end
            default: begin e.red = 2'b11; e.fr = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic cyc(input logic r, input logic freq, input logic fl,
                       input int st, input int ph, input int el,
                       input logic pend, input logic blink);
        item_t it;
        rst      = r;
        farm_req = freq;
        flash    = fl;
        it.e     = mk(st, ph, el, pend, blink);
        it.scen  = scen;
        it.cyc   = cyc_i;
        exp_q.push_back(it);
        cyc_i++;
        @(negedge clk);
    endtask

    task automatic seg(input logic freq, input logic fl, input int st, input int ph,
                       input int el0, input int n, input logic pend);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, freq, fl, st, ph, el0 + i, pend, 1'b1);
        end
    endtask

    // Holds reset two edges and releases it on a falling edge: that cycle is cycle 0.
    task automatic do_reset(input int s);
        rst      = 1'b1;
        farm_req = 1'b0;
        flash    = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        scen  = s;
        cyc_i = 0;
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    initial begin
        item_t it;
        obs_t  a;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                a  = {green, yellow, red, fg, fy, fr, phase, elapsed, farm_pending};
                n_vec++;
                if (a !== it.e) begin
                    n_miss++;
                    $display("FAIL s%0d_c%0d: got g=%b y=%b r=%b fg/fy/fr=%b%b%b ph=%0d el=%0d pend=%b, want g=%b y=%b r=%b fg/fy/fr=%b%b%b ph=%0d el=%0d pend=%b",
                             it.scen, it.cyc, a.green, a.yellow, a.red, a.fg, a.fy, a.fr,
                             a.phase, a.elapsed, a.pend, it.e.green, it.e.yellow, it.e.red,
                             it.e.fg, it.e.fy, it.e.fr, it.e.phase, it.e.elapsed, it.e.pend);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        farm_req = 1'b0;
        flash    = 1'b0;
        @(negedge clk);

        // 1: idle round robin with wrap back to phase 0
        do_reset(1);
        seg(1'b0, 1'b0, ST_G, 0, 0, 8, 1'b0);
        seg(1'b0, 1'b0, ST_Y, 0, 0, 3, 1'b0);
        seg(1'b0, 1'b0, ST_A, 0, 0, 2, 1'b0);
        seg(1'b0, 1'b0, ST_G, 1, 0, 8, 1'b0);
        seg(1'b0, 1'b0, ST_Y, 1, 0, 3, 1'b0);
        seg(1'b0, 1'b0, ST_A, 1, 0, 2, 1'b0);
        seg(1'b0, 1'b0, ST_G, 0, 0, 1, 1'b0);

        // 2: single pulse at cycle 3, minimum farm green via gap-out
        do_reset(2);
        seg(1'b0, 1'b0, ST_G, 0, 0, 3, 1'b0);
        seg(1'b1, 1'b0, ST_G, 0, 3, 1, 1'b0);
        seg(1'b0, 1'b0, ST_G, 0, 4, 4, 1'b1);
        seg(1'b0, 1'b0, ST_Y, 0, 0, 3, 1'b1);
        seg(1'b0, 1'b0, ST_A, 0, 0, 2, 1'b1);
        seg(1'b0, 1'b0, ST_FG, 0, 0, 4, 1'b0);
        seg(1'b0, 1'b0, ST_FY, 0, 0, 3, 1'b0);
        seg(1'b0, 1'b0, ST_A, 0, 0, 2, 1'b0);
        seg(1'b0, 1'b0, ST_G, 1, 0, 1, 1'b0);

        // 3: request held high, maximum farm green, no back-to-back service
        do_reset(3);
        seg(1'b1, 1'b0, ST_G, 0, 0, 1, 1'b0);
        seg(1'b1, 1'b0, ST_G, 0, 1, 7, 1'b1);
        seg(1'b1, 1'b0, ST_Y, 0, 0, 3, 1'b1);
        seg(1'b1, 1'b0, ST_A, 0, 0, 2, 1'b1);
        seg(1'b1, 1'b0, ST_FG, 0, 0, 10, 1'b0);
        seg(1'b1, 1'b0, ST_FY, 0, 0, 1, 1'b0);
        seg(1'b1, 1'b0, ST_FY, 0, 1, 2, 1'b1);
        seg(1'b1, 1'b0, ST_A, 0, 0, 2, 1'b1);
        seg(1'b1, 1'b0, ST_G, 1, 0, 8, 1'b1);
        seg(1'b1, 1'b0, ST_Y, 1, 0, 3, 1'b1);
        seg(1'b1, 1'b0, ST_A, 1, 0, 2, 1'b1);
        seg(1'b1, 1'b0, ST_FG, 1, 0, 1, 1'b0);

        // 4: request drops at farm elapsed 6, green lasts 7 cycles
        do_reset(4);
        seg(1'b1, 1'b0, ST_G, 0, 0, 1, 1'b0);
        seg(1'b1, 1'b0, ST_G, 0, 1, 7, 1'b1);
        seg(1'b1, 1'b0, ST_Y, 0, 0, 3, 1'b1);
        seg(1'b1, 1'b0, ST_A, 0, 0, 2, 1'b1);
        seg(1'b1, 1'b0, ST_FG, 0, 0, 6, 1'b0);
        seg(1'b0, 1'b0, ST_FG, 0, 6, 1, 1'b0);
        seg(1'b0, 1'b0, ST_FY, 0, 0, 3, 1'b0);
        seg(1'b0, 1'b0, ST_A, 0, 0, 2, 1'b0);
        seg(1'b0, 1'b0, ST_G, 1, 0, 1, 1'b0);

        // 5: flash during green[1]; request latched in flash served after one main phase
        do_reset(5);
        seg(1'b0, 1'b0, ST_G, 0, 0, 8, 1'b0);
        seg(1'b0, 1'b0, ST_Y, 0, 0, 3, 1'b0);
        seg(1'b0, 1'b0, ST_A, 0, 0, 2, 1'b0);
        seg(1'b0, 1'b0, ST_G, 1, 0, 2, 1'b0);
        seg(1'b0, 1'b1, ST_G, 1, 2, 1, 1'b0);
        for (int k = 0; k < 13; k++) begin
            cyc(1'b0, (k == 5) ? 1'b1 : 1'b0, (k < 12) ? 1'b1 : 1'b0, ST_FL, 1, k % 4,
                (k >= 6) ? 1'b1 : 1'b0, ((k / 4) % 2 == 0) ? 1'b1 : 1'b0);
        end
        seg(1'b0, 1'b0, ST_A, 1, 0, 2, 1'b1);
        seg(1'b0, 1'b0, ST_G, 0, 0, 8, 1'b1);
        seg(1'b0, 1'b0, ST_Y, 0, 0, 3, 1'b1);
        seg(1'b0, 1'b0, ST_A, 0, 0, 2, 1'b1);
        seg(1'b0, 1'b0, ST_FG, 0, 0, 1, 1'b0);

        // 6: asynchronous reset in farm green at elapsed 5, then normal restart
        do_reset(6);
        seg(1'b1, 1'b0, ST_G, 0, 0, 1, 1'b0);
        seg(1'b1, 1'b0, ST_G, 0, 1, 7, 1'b1);
        seg(1'b1, 1'b0, ST_Y, 0, 0, 3, 1'b1);
        seg(1'b1, 1'b0, ST_A, 0, 0, 2, 1'b1);
        seg(1'b1, 1'b0, ST_FG, 0, 0, 5, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, ST_G, 0, 0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, ST_G, 0, 0, 1'b0, 1'b1);
        seg(1'b0, 1'b0, ST_G, 0, 0, 8, 1'b0);
        seg(1'b0, 1'b0, ST_Y, 0, 0, 3, 1'b0);
        seg(1'b0, 1'b0, ST_A, 0, 0, 2, 1'b0);
        seg(1'b0, 1'b0, ST_G, 1, 0, 1, 1'b0);

        @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations never compared, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
